// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// State encoding and tenure-counter width.
package wshb_arb_pkg;

   localparam int QCNT_W = 8;

   typedef logic [QCNT_W-1:0] qcnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bundle between a requester and a target.
// master drives the request side, slave returns data and termination.
interface wshb_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [AW-1:0]   adr;
   logic [DW/8-1:0] sel;
   logic [DW-1:0]   dat_ms;
   logic [DW-1:0]   dat_sm;
   logic            ack;
   logic            err;
   logic [2:0]      cti;
   logic [1:0]      bte;

   modport master (
      output cyc, stb, we, adr, sel, dat_ms, cti, bte,
      input  dat_sm, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
      output dat_sm, ack, err
   );

endinterface

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone arbiter with round robin and ack-quantum preemption.
// Optional per-master statistics when ARB_STATS_EN is defined.
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int QUANTUM = 16,
   parameter bit FIRST   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   wshb_if.slave      wshb_s0,
   wshb_if.slave      wshb_s1,
   wshb_if.master     wshb_m,
   output logic [1:0] grant
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] stat_ack0,
   output logic [31:0] stat_ack1,
   output logic [15:0] stat_preempt
`endif
);

   localparam qcnt_t QMAX = qcnt_t'(QUANTUM);

   arb_state_e      state_q, state_d;
   qcnt_t           cnt_q, cnt_d;
   logic            last_q, last_d;
   logic            cyc0, cyc1;
   logic            end_ev;
   logic [QCNT_W:0] cnt_nx;
   logic            cnt_full;

   assign cyc0     = wshb_s0.cyc;
   assign cyc1     = wshb_s1.cyc;
   assign end_ev   = (state_q != IDLE) && (wshb_m.ack || wshb_m.err);
   assign cnt_nx   = {1'b0, cnt_q} + {{QCNT_W{1'b0}}, 1'b1};
   assign cnt_full = cnt_nx >= {1'b0, QMAX};
   assign grant    = {state_q == GNT1, state_q == GNT0};

   // arbitration: idle pick, release handover, quantum preemption
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cyc0 && cyc1)
               state_d = last_q ? GNT0 : GNT1;
            else if (cyc0)
               state_d = GNT0;
            else if (cyc1)
               state_d = GNT1;
         end
         GNT0: begin
            if (!cyc0)
               state_d = cyc1 ? GNT1 : IDLE;
            else if (cyc1 && end_ev && cnt_full)
               state_d = GNT1;
         end
         GNT1: begin
            if (!cyc1)
               state_d = cyc0 ? GNT0 : IDLE;
            else if (cyc0 && end_ev && cnt_full)
               state_d = GNT0;
         end
         default: state_d = IDLE;
      endcase
   end

   // tenure counter: cleared on grant change, saturates at the quantum
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (end_ev)
         cnt_d = (cnt_q >= QMAX) ? QMAX : cnt_nx[QCNT_W-1:0];
   end

   // remember which master owned the bus most recently
   always_comb begin
      last_d = last_q;
      if (state_q == GNT0)
         last_d = 1'b0;
      else if (state_q == GNT1)
         last_d = 1'b1;
   end

   // state, tenure and history registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= ~FIRST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // read data goes to both requesters; only the owner sees termination
   assign wshb_s0.dat_sm = wshb_m.dat_sm;
   assign wshb_s1.dat_sm = wshb_m.dat_sm;

   // zero-latency request mux and response steering
   always_comb begin
      wshb_m.cyc    = 1'b0;
      wshb_m.stb    = 1'b0;
      wshb_m.we     = 1'b0;
      wshb_m.adr    = '0;
      wshb_m.sel    = '0;
      wshb_m.dat_ms = '0;
      wshb_m.cti    = '0;
      wshb_m.bte    = '0;
      wshb_s0.ack   = 1'b0;
      wshb_s0.err   = 1'b0;
      wshb_s1.ack   = 1'b0;
      wshb_s1.err   = 1'b0;
      unique case (state_q)
         GNT0: begin
            wshb_m.cyc    = wshb_s0.cyc;
            wshb_m.stb    = wshb_s0.stb;
            wshb_m.we     = wshb_s0.we;
            wshb_m.adr    = wshb_s0.adr;
            wshb_m.sel    = wshb_s0.sel;
            wshb_m.dat_ms = wshb_s0.dat_ms;
            wshb_m.cti    = wshb_s0.cti;
            wshb_m.bte    = wshb_s0.bte;
            wshb_s0.ack   = wshb_m.ack;
            wshb_s0.err   = wshb_m.err;
         end
         GNT1: begin
            wshb_m.cyc    = wshb_s1.cyc;
            wshb_m.stb    = wshb_s1.stb;
            wshb_m.we     = wshb_s1.we;
            wshb_m.adr    = wshb_s1.adr;
            wshb_m.sel    = wshb_s1.sel;
            wshb_m.dat_ms = wshb_s1.dat_ms;
            wshb_m.cti    = wshb_s1.cti;
            wshb_m.bte    = wshb_s1.bte;
            wshb_s1.ack   = wshb_m.ack;
            wshb_s1.err   = wshb_m.err;
         end
         default: ;
      endcase
   end

`ifdef ARB_STATS_EN
   logic [31:0] sack0_q, sack1_q;
   logic [15:0] spre_q;
   logic        preempt;

   assign preempt = ((state_q == GNT0) && cyc0 && (state_d == GNT1)) ||
                    ((state_q == GNT1) && cyc1 && (state_d == GNT0));

   // delivered-ack counters wrap, preemption counter saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sack0_q <= '0;
         sack1_q <= '0;
         spre_q  <= '0;
      end else begin
         if ((state_q == GNT0) && wshb_m.ack)
            sack0_q <= sack0_q + 32'd1;
         if ((state_q == GNT1) && wshb_m.ack)
            sack1_q <= sack1_q + 32'd1;
         if (preempt && (spre_q != 16'hFFFF))
            spre_q <= spre_q + 16'd1;
      end
   end

   assign stat_ack0    = sack0_q;
   assign stat_ack1    = sack1_q;
   assign stat_preempt = spre_q;
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Randomized bench for wshb_arbiter against a behavioural ownership model.
// Two requester engines, one random-latency target, directed scenarios.
module tb_wshb_arbiter;

   localparam int Q     = 4;
   localparam bit FIRST = 1'b0;
   localparam logic [31:0] RDK = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wshb_if s0_if ();
   wshb_if s1_if ();
   wshb_if m_if ();
   logic [1:0] grant;

`ifdef ARB_STATS_EN
   logic [31:0] stat_ack0, stat_ack1;
   logic [15:0] stat_preempt;
`endif

   wshb_arbiter #(.QUANTUM(Q), .FIRST(FIRST)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wshb_s0 (s0_if),
      .wshb_s1 (s1_if),
      .wshb_m  (m_if),
      .grant   (grant)
`ifdef ARB_STATS_EN
      ,
      .stat_ack0    (stat_ack0),
      .stat_ack1    (stat_ack1),
      .stat_preempt (stat_preempt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // requester engine state
   int          n [2];
   logic        mcyc [2], mstb [2], mwe [2];
   logic [31:0] madr [2], mdat [2];
   logic [3:0]  msel [2];
   logic [2:0]  mcti [2];
   logic [1:0]  mbte [2];
   bit          done [2];
   int          ends [2], acks_rx [2];
   int          chain_n1 = 0;
   bit          rd_only = 0, err_en = 1, stb_dense = 0;

   // target response of the current cycle
   logic        sack, serr;
   logic [31:0] sdat;

   // ownership model: -1 idle, else owning master
   int own, ten, last;
   int exp_ack [2];
   int exp_pre;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_masters();
      s0_if.cyc = mcyc[0]; s0_if.stb = mstb[0]; s0_if.we = mwe[0];
      s0_if.adr = madr[0]; s0_if.sel = msel[0]; s0_if.dat_ms = mdat[0];
      s0_if.cti = mcti[0]; s0_if.bte = mbte[0];
      s1_if.cyc = mcyc[1]; s1_if.stb = mstb[1]; s1_if.we = mwe[1];
      s1_if.adr = madr[1]; s1_if.sel = msel[1]; s1_if.dat_ms = mdat[1];
      s1_if.cti = mcti[1]; s1_if.bte = mbte[1];
   endtask

   task automatic model_reset();
      own = -1;
      ten = 0;
      last = 1 - int'(FIRST);
      exp_ack[0] = 0; exp_ack[1] = 0;
      exp_pre = 0;
   endtask

   task automatic clear_masters();
      for (int i = 0; i < 2; i++) begin
         n[i] = 0; mcyc[i] = 0; mstb[i] = 0; done[i] = 0;
      end
      chain_n1 = 0;
      drive_masters();
   endtask

   task automatic tick();
      int nxt;
      bit endo;
      bit c [2];
      logic [127:0] expb;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (done[i]) begin
            n[i]--;
            madr[i] += 32'd4;
            if (i == 0 && n[0] == 0 && chain_n1 > 0) begin
               n[1] = chain_n1;
               chain_n1 = 0;
            end
         end
         if (n[i] > 0) begin
            if (!mcyc[i] || !mstb[i] || done[i]) begin
               mstb[i] = stb_dense ? 1'b1 : ($urandom_range(0, 3) != 0);
               if (mstb[i]) begin
                  mwe[i]  = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
                  msel[i] = 4'($urandom);
                  mdat[i] = $urandom;
                  mcti[i] = 3'($urandom);
                  mbte[i] = 2'($urandom);
               end
            end
            mcyc[i] = 1'b1;
         end else begin
            mcyc[i] = 1'b0;
            mstb[i] = 1'b0;
         end
      end
      drive_masters();
      #1;
      sack = 1'b0; serr = 1'b0; sdat = $urandom;
      if (m_if.cyc && m_if.stb && $urandom_range(0, 2) != 0) begin
         if (err_en && $urandom_range(0, 7) == 0) serr = 1'b1;
         else begin
            sack = 1'b1;
            sdat = m_if.adr ^ RDK;
         end
      end
      m_if.ack = sack; m_if.err = serr; m_if.dat_sm = sdat;
      #1;
      chk("grant", grant, own == 0 ? 2'b01 : own == 1 ? 2'b10 : 2'b00);
      if (own >= 0)
         expb = {mcyc[own], mstb[own], mwe[own], madr[own], msel[own],
                 mdat[own], mcti[own], mbte[own]};
      else
         expb = '0;
      chk("m_bus", {m_if.cyc, m_if.stb, m_if.we, m_if.adr, m_if.sel,
                    m_if.dat_ms, m_if.cti, m_if.bte}, expb);
      chk("s0_resp", {s0_if.ack, s0_if.err},
          own == 0 ? {sack, serr} : 2'b00);
      chk("s1_resp", {s1_if.ack, s1_if.err},
          own == 1 ? {sack, serr} : 2'b00);
      chk("dat_bcast", {s0_if.dat_sm, s1_if.dat_sm}, {sdat, sdat});
      if (s0_if.ack && !mwe[0]) chk("rd_data0", s0_if.dat_sm, madr[0] ^ RDK);
      if (s1_if.ack && !mwe[1]) chk("rd_data1", s1_if.dat_sm, madr[1] ^ RDK);
      done[0] = s0_if.ack | s0_if.err;
      done[1] = s1_if.ack | s1_if.err;
      for (int i = 0; i < 2; i++) begin
         if (done[i]) ends[i]++;
      end
      if (s0_if.ack) acks_rx[0]++;
      if (s1_if.ack) acks_rx[1]++;
      // next owner from this cycle's requests and terminations
      c[0] = mcyc[0]; c[1] = mcyc[1];
      endo = (own >= 0) && (sack || serr);
      if (own < 0) begin
         if (c[0] && c[1]) nxt = 1 - last;
         else if (c[0]) nxt = 0;
         else if (c[1]) nxt = 1;
         else nxt = -1;
      end else begin
         if (!c[own]) nxt = c[1-own] ? 1 - own : -1;
         else if (endo && c[1-own] && ten + 1 >= Q) nxt = 1 - own;
         else nxt = own;
         if (sack) exp_ack[own]++;
         if (c[own] && nxt != own) exp_pre++;
      end
      if (nxt != own) ten = 0;
      else if (endo) ten = (ten + 1 > Q) ? Q : ten + 1;
      if (nxt >= 0) last = nxt;
      own = nxt;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         if (n[0] == 0 && n[1] == 0 && !mcyc[0] && !mcyc[1] &&
             grant === 2'b00) break;
         tick();
      end
      chk("idle_timeout", 1'(k < budget), 1'b1);
   endtask

   task automatic zero_counts();
      for (int i = 0; i < 2; i++) begin
         ends[i] = 0; acks_rx[i] = 0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      m_if.ack = 1'b1; m_if.err = 1'b1;
      #1;
      chk("rst_m_cs", {m_if.cyc, m_if.stb}, 2'b00);
      chk("rst_grant", grant, 2'b00);
      chk("rst_resp", {s0_if.ack, s0_if.err, s1_if.ack, s1_if.err}, 4'h0);
`ifdef ARB_STATS_EN
      chk("rst_stats", {stat_ack0, stat_ack1, stat_preempt}, 80'h0);
`endif
      clear_masters();
      m_if.ack = 1'b0; m_if.err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_stats_check();
`ifdef ARB_STATS_EN
      chk("stat_ack0", stat_ack0, 32'(exp_ack[0]));
      chk("stat_ack1", stat_ack1, 32'(exp_ack[1]));
      chk("stat_preempt", stat_preempt, 16'(exp_pre));
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      bit seen01;
      int k;
      for (int i = 0; i < 2; i++) begin
         madr[i] = 32'h1000 * (i + 1); mdat[i] = '0; msel[i] = '0;
         mwe[i] = 0; mcti[i] = '0; mbte[i] = '0;
      end
      clear_masters();
      zero_counts();
      model_reset();
      m_if.dat_sm = '0;

      // reset with a live request and a stray target ack
      rst_n = 1'b0;
      mcyc[0] = 1'b1; mstb[0] = 1'b1;
      drive_masters();
      m_if.ack = 1'b1; m_if.err = 1'b0;
      #1;
      chk("r027_m_cyc", m_if.cyc, 1'b0);
      chk("r027_grant", grant, 2'b00);
      chk("r027_s0_ack", s0_if.ack, 1'b0);
      clear_masters();
      m_if.ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single requester, five reads
      rd_only = 1; err_en = 0;
      zero_counts();
      n[0] = 5;
      tick();
      chk("r028_req_cycle", grant, 2'b00);
      tick();
      chk("r028_grant", grant, 2'b01);
      wait_idle(200);
      chk("r028_s0_acks", acks_rx[0], 5);
      chk("r028_s1_acks", acks_rx[1], 0);
      chk("r028_idle", grant, 2'b00);

      // simultaneous contests right after reset
      pulse_reset();
      n[0] = 2; n[1] = 1;
      tick();
      tick();
      chk("r029_first", grant, 2'b01);
      n[1] = 0;
      wait_idle(200);
      n[0] = 1; n[1] = 1;
      tick();
      tick();
      chk("r029_rr", grant, 2'b10);
      wait_idle(200);

      // quantum preemption with a long stream
      pulse_reset();
      zero_counts();
      stb_dense = 1;
      n[0] = 20;
      tick();
      n[1] = 6;
      for (k = 0; k < 200; k++) begin
         tick();
         if (grant === 2'b10) break;
      end
      chk("r030_switch", 1'(k < 200), 1'b1);
      chk("r030_quantum", acks_rx[0], Q);
      chk("r030_stall", {s0_if.cyc, s0_if.stb, s0_if.ack}, 3'b110);
      wait_idle(400);
      chk("r030_s0_total", acks_rx[0], 20);
      chk("r030_s1_total", acks_rx[1], 6);
      run_stats_check();
      stb_dense = 0;

      // release handover without idle bubble
      rd_only = 0; err_en = 1;
      n[0] = 3; chain_n1 = 3;
      gap = 0; seen01 = 0;
      for (k = 0; k < 200; k++) begin
         tick();
         if (grant === 2'b01) seen01 = 1;
         else if (seen01 && grant === 2'b00) gap++;
         if (grant === 2'b10) break;
      end
      chk("r031_reached", {1'(k < 200), seen01}, 2'b11);
      chk("r031_gap", gap, 0);
      wait_idle(200);

      // random traffic from both requesters
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < 2; i++)
            if (n[i] == 0 && $urandom_range(0, 5) == 0)
               n[i] = $urandom_range(1, 12);
         tick();
      end
      wait_idle(1000);
      run_stats_check();

      // reset in the middle of a transfer, then re-arbitrate
      n[0] = 10;
      repeat (4) tick();
      pulse_reset();
      zero_counts();
      n[1] = 2;
      wait_idle(200);
      chk("r022_rearb", ends[1], 2);
      run_stats_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
